// File: rtl/dispatch_unit_pkg.sv
// dispatch_unit_pkg: shared constants for the queued dispatcher
//   TRUE/FALSE       : single-bit boolean constants
//   LSB_BIT          : to_lsb bit selecting the LoadStoreBuffer target
//   STORE_BIT        : to_lsb bit marking a store (1) or load (0)
//   DEF_*            : default widths/depth used as parameter defaults
package dispatch_unit_pkg;
   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;
   localparam int LSB_BIT   = 1;
   localparam int STORE_BIT = 0;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_WORD_W  = 32;
   localparam int DEF_INST_W  = 6;
   localparam int DEF_TAG_W   = 4;
   localparam int DEF_REG_W   = 5;
   localparam int DEF_SHAMT_W = 5;
endpackage

// File: rtl/dispatch_unit_fifo.sv
// dispatch_fifo: DEPTH x W circular buffer holding packed decoded instructions
//   clk, rst      : clock, synchronous active-low reset
//   i_clr         : flush, empties the queue
//   i_push/i_data : write i_data at tail (caller guarantees !o_full)
//   i_pop         : advance head (caller guarantees !o_empty)
//   o_data        : current head entry
//   o_empty/o_full/o_count : occupancy status
module dispatch_fifo
   import dispatch_unit_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_clr,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [W-1:0]               i_data,
   output logic [W-1:0]               o_data,
   output logic                       o_empty,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   always_ff @(posedge clk) begin
      if (!rst || i_clr) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop)  r_rd <= r_rd + 1'b1;
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end
   // payload storage needs no reset; occupancy guards every read
   always_ff @(posedge clk) begin
      if (rst && !i_clr && i_push) r_mem[r_wr] <= i_data;
   end
   assign o_data  = r_mem[r_rd];
   assign o_count = r_count;
   assign o_empty = r_count == '0;
   assign o_full  = r_count == (AW+1)'(DEPTH);
endmodule

// File: rtl/dispatch_unit.sv
// dispatch_unit: queued dispatcher issuing decoded instructions to RS or LSB with a ROB tag
//   clk, rst                 : clock, synchronous active-low reset
//   clr_in                   : mispredict flush (active-high, synchronous)
//   dec_valid_in/dec_ready_out : decoder handshake (ready = queue not full)
//   dec_*_in                 : instruction payload and dec_to_lsb_in ([1]=LSB, [0]=store)
//   rob_free_in/rob_tag_in   : ROB space and tag for the next allocation
//   rs_free_in/lsb_free_in   : target slot availability
//   rob_alloc_out, rs_new_inst_out, lsb_new_inst_out : one-cycle issue pulses
//   lsb_store_out            : store flag, valid with lsb_new_inst_out
//   *_out payload, dest_out  : registered issued instruction and its ROB tag
// Optional macro DISPATCH_BYPASS_EN: an instruction accepted into an empty queue
// whose targets are free issues at the accept edge instead of being queued.
module dispatch_unit
   import dispatch_unit_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int WORD_W  = DEF_WORD_W,
   parameter int INST_W  = DEF_INST_W,
   parameter int TAG_W   = DEF_TAG_W,
   parameter int REG_W   = DEF_REG_W,
   parameter int SHAMT_W = DEF_SHAMT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_in,
   input  logic               dec_valid_in,
   output logic               dec_ready_out,
   input  logic [INST_W-1:0]  dec_inst_in,
   input  logic [WORD_W-1:0]  dec_imm_in,
   input  logic [WORD_W-1:0]  dec_pc_in,
   input  logic [REG_W-1:0]   dec_rs1_in,
   input  logic [REG_W-1:0]   dec_rs2_in,
   input  logic [REG_W-1:0]   dec_rd_in,
   input  logic [SHAMT_W-1:0] dec_shamt_in,
   input  logic [1:0]         dec_to_lsb_in,
   input  logic               rob_free_in,
   input  logic [TAG_W-1:0]   rob_tag_in,
   input  logic               rs_free_in,
   input  logic               lsb_free_in,
   output logic               rob_alloc_out,
   output logic               rs_new_inst_out,
   output logic               lsb_new_inst_out,
   output logic               lsb_store_out,
   output logic [INST_W-1:0]  inst_out,
   output logic [WORD_W-1:0]  imm_out,
   output logic [WORD_W-1:0]  pc_out,
   output logic [REG_W-1:0]   rs1_out,
   output logic [REG_W-1:0]   rs2_out,
   output logic [REG_W-1:0]   rd_out,
   output logic [SHAMT_W-1:0] shamt_out,
   output logic [TAG_W-1:0]   dest_out
);
   localparam int PW = 2 + INST_W + 2*WORD_W + 3*REG_W + SHAMT_W;
   logic [PW-1:0]          w_din;
   logic [PW-1:0]          w_head;
   logic [PW-1:0]          w_issue;
   logic                   w_empty;
   logic                   w_full;
   logic [$clog2(DEPTH):0] w_count;
   logic                   w_accept;
   logic                   w_fire_q;
   logic                   w_byp;
   logic                   w_fire;
   logic                   w_push;
   logic [1:0]             w_head_to_lsb;
   logic [1:0]             w_to_lsb;
   logic [INST_W-1:0]      w_inst;
   logic [WORD_W-1:0]      w_imm;
   logic [WORD_W-1:0]      w_pc;
   logic [REG_W-1:0]       w_rs1;
   logic [REG_W-1:0]       w_rs2;
   logic [REG_W-1:0]       w_rd;
   logic [SHAMT_W-1:0]     w_shamt;
   logic                   r_alloc;
   logic                   r_rs;
   logic                   r_lsb;
   logic                   r_store;
   logic [INST_W-1:0]      r_inst;
   logic [WORD_W-1:0]      r_imm;
   logic [WORD_W-1:0]      r_pc;
   logic [REG_W-1:0]       r_rs1;
   logic [REG_W-1:0]       r_rs2;
   logic [REG_W-1:0]       r_rd;
   logic [SHAMT_W-1:0]     r_shamt;
   logic [TAG_W-1:0]       r_dest;
   assign w_din = {dec_to_lsb_in, dec_inst_in, dec_imm_in, dec_pc_in,
                   dec_rs1_in, dec_rs2_in, dec_rd_in, dec_shamt_in};
   dispatch_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (clr_in),
      .i_push  (w_push),
      .i_pop   (w_fire_q),
      .i_data  (w_din),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_count)
   );
   // readiness ignores a same-cycle pop so it depends on occupancy only
   assign dec_ready_out = !w_full;
   assign w_accept      = dec_valid_in && dec_ready_out && !clr_in;
   assign w_head_to_lsb = w_head[PW-1 -: 2];
   assign w_fire_q = !w_empty && rob_free_in && !clr_in &&
                     (w_head_to_lsb[LSB_BIT] ? lsb_free_in : rs_free_in);
`ifdef DISPATCH_BYPASS_EN
   assign w_byp = w_empty && w_accept && rob_free_in &&
                  (dec_to_lsb_in[LSB_BIT] ? lsb_free_in : rs_free_in);
`else
   assign w_byp = FALSE;
`endif
   assign w_fire  = w_fire_q || w_byp;
   assign w_push  = w_accept && !w_byp;
   assign w_issue = w_byp ? w_din : w_head;
   assign {w_to_lsb, w_inst, w_imm, w_pc, w_rs1, w_rs2, w_rd, w_shamt} = w_issue;
   // clr_in is already folded into w_fire, so a flush edge drops all pulses
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_alloc <= FALSE;
         r_rs    <= FALSE;
         r_lsb   <= FALSE;
         r_store <= FALSE;
         r_inst  <= '0;
         r_imm   <= '0;
         r_pc    <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
         r_shamt <= '0;
         r_dest  <= '0;
      end else begin
         r_alloc <= w_fire;
         r_rs    <= w_fire && !w_to_lsb[LSB_BIT];
         r_lsb   <= w_fire && w_to_lsb[LSB_BIT];
         r_store <= w_fire && w_to_lsb[STORE_BIT];
         if (w_fire) begin
            r_inst  <= w_inst;
            r_imm   <= w_imm;
            r_pc    <= w_pc;
            r_rs1   <= w_rs1;
            r_rs2   <= w_rs2;
            r_rd    <= w_rd;
            r_shamt <= w_shamt;
            r_dest  <= rob_tag_in;
         end
      end
   end
   assign rob_alloc_out    = r_alloc;
   assign rs_new_inst_out  = r_rs;
   assign lsb_new_inst_out = r_lsb;
   assign lsb_store_out    = r_store;
   assign inst_out         = r_inst;
   assign imm_out          = r_imm;
   assign pc_out           = r_pc;
   assign rs1_out          = r_rs1;
   assign rs2_out          = r_rs2;
   assign rd_out           = r_rd;
   assign shamt_out        = r_shamt;
   assign dest_out         = r_dest;
endmodule
